// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// FSM state encoding plus default RAM depth and register-tag width.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam int MEM_DEPTH_DEF = 10;
    localparam int REG_TAG_W     = 5;

endpackage

// File: rtl/mem_access_stage.sv
// Memory-access stage: one load/store in flight, registered RAM controls.
// Optional address bounds check enabled by MEM_ACCESS_BOUNDS_CHK_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [REG_TAG_W-1:0] req_rd,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_data,
    output logic [REG_TAG_W-1:0] resp_rd,
    output logic                 resp_err,
    output logic                 ram_opM,
    output logic                 ram_opR,
    output logic [ADDR_W-1:0]    ram_pos,
    output logic [DATA_W-1:0]    ram_valor,
    input  logic [DATA_W-1:0]    ram_salida
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             oob;

`ifdef MEM_ACCESS_BOUNDS_CHK_EN
    logic err_q;
    assign oob      = (req_addr >= ADDR_W'(MEM_DEPTH));
    assign resp_err = err_q;
`else
    logic unused_depth;
    assign unused_depth = (MEM_DEPTH != 0);
    assign oob          = 1'b0;
    assign resp_err     = 1'b0;
`endif

    assign req_ready = (state == IDLE);

    // Async reset drops ram_opM at once since the RAM writes on the level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ram_opM    <= 1'b0;
            ram_opR    <= 1'b0;
            ram_pos    <= '0;
            ram_valor  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
`ifdef MEM_ACCESS_BOUNDS_CHK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        ram_pos   <= req_addr;
                        ram_valor <= req_wdata;
                        resp_rd   <= req_rd;
                        resp_data <= '0;
`ifdef MEM_ACCESS_BOUNDS_CHK_EN
                        err_q     <= oob;
`endif
                        if (oob) begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (req_we) begin
                            ram_opM <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            ram_opR <= 1'b1;
                            cnt     <= CNT_INIT;
                            state   <= READ_WAIT;
                        end
                    end
                end
                WRITE: begin
                    ram_opM    <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                READ_WAIT: begin
                    if (cnt == '0) begin
                        ram_opR    <= 1'b0;
                        resp_data  <= ram_salida;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with RD_LAT=1 and RD_LAT=3 instances.
// Scoreboard queues hold expected responses; monitors pop on handshake.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rd = '0;

    logic        v1 = 1'b0, rr1 = 1'b1;
    logic        v3 = 1'b0, rr3 = 1'b1;

    logic        rdy1, rv1, err1, opm1, opr1;
    logic [31:0] data1, pos1, valor1, sal1;
    logic [4:0]  rd1;
    logic        rdy3, rv3, err3, opm3, opr3;
    logic [31:0] data3, pos3, valor3, sal3;
    logic [4:0]  rd3;

    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];

    logic [37:0] q1 [$];
    logic [37:0] q3 [$];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v1), .req_ready(rdy1), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_rd(rd),
        .resp_valid(rv1), .resp_ready(rr1), .resp_data(data1),
        .resp_rd(rd1), .resp_err(err1),
        .ram_opM(opm1), .ram_opR(opr1), .ram_pos(pos1),
        .ram_valor(valor1), .ram_salida(sal1)
    );

    mem_access_stage #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v3), .req_ready(rdy3), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_rd(rd),
        .resp_valid(rv3), .resp_ready(rr3), .resp_data(data3),
        .resp_rd(rd3), .resp_err(err3),
        .ram_opM(opm3), .ram_opR(opr3), .ram_pos(pos3),
        .ram_valor(valor3), .ram_salida(sal3)
    );

    // RAM models: async read, write on the clock while opM is high
    assign sal1 = mem1[pos1[3:0]];
    assign sal3 = mem3[pos3[3:0]];

    always @(posedge clk) begin
        if (opm1) mem1[pos1[3:0]] <= valor1;
        if (opm3) mem3[pos3[3:0]] <= valor3;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("excl1", 64'(opm1 & opr1), 64'd0);
            chk("excl3", 64'(opm3 & opr3), 64'd0);
            if (rv1 && rr1) begin
                if (q1.size() == 0) chk("sb1_empty", 64'd1, 64'd0);
                else chk("sb1_resp", {26'd0, data1, rd1, err1},
                         {26'd0, q1.pop_front()});
            end
            if (rv3 && rr3) begin
                if (q3.size() == 0) chk("sb3_empty", 64'd1, 64'd0);
                else chk("sb3_resp", {26'd0, data3, rd3, err3},
                         {26'd0, q3.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request; returns #1 into the cycle after acceptance
    task automatic send(input bit sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r,
                        input logic [37:0] exp);
        bit rdy;
        bit ok = 1'b0;
        we = w; addr = a; wdata = d; rd = r;
        if (sel) v3 = 1'b1; else v1 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rdy = sel ? rdy3 : rdy1;
            if (rdy) begin
                if (sel) q3.push_back(exp); else q1.push_back(exp);
            end
            step();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        v1 = 1'b0;
        v3 = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 32'hA000_0000 | 32'(i);
            mem3[i] = 32'hB000_0000 | 32'(i);
        end

        step();
        step();
        chk("rst_ready", 64'(rdy1), 64'd1);
        chk("rst_outs", {opm1, opr1, rv1, err1, rd1}, 64'd0);
        chk("rst_pos", {pos1, valor1}, 64'd0);
        chk("rst_data", 64'(data1), 64'd0);
        rst_n = 1'b1;
        step();

        // Store
        send(1'b0, 1'b1, 32'd3, 32'hDEAD_BEEF, 5'd0, {32'd0, 5'd0, 1'b0});
        chk("st_opm", 64'(opm1), 64'd1);
        chk("st_pos", 64'(pos1), 64'd3);
        chk("st_valor", 64'(valor1), 64'hDEAD_BEEF);
        chk("st_rv_early", 64'(rv1), 64'd0);
        step();
        chk("st_opm_drop", 64'(opm1), 64'd0);
        chk("st_rv", 64'(rv1), 64'd1);
        step();

        // Load back, RD_LAT=1
        send(1'b0, 1'b0, 32'd3, 32'd0, 5'd4, {32'hDEAD_BEEF, 5'd4, 1'b0});
        chk("ld_opr", 64'(opr1), 64'd1);
        chk("ld_opm", 64'(opm1), 64'd0);
        chk("ld_rv_early", 64'(rv1), 64'd0);
        step();
        chk("ld_opr_drop", 64'(opr1), 64'd0);
        chk("ld_rv", 64'(rv1), 64'd1);
        step();

        // Back-pressure with a second request waiting
        rr1 = 1'b0;
        send(1'b0, 1'b0, 32'd3, 32'd0, 5'd7, {32'hDEAD_BEEF, 5'd7, 1'b0});
        step();
        we = 1'b1; addr = 32'd5; wdata = 32'h1234_5678; rd = 5'd9;
        v1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rv", 64'(rv1), 64'd1);
            chk("bp_hold", {data1, rd1, err1}, {32'hDEAD_BEEF, 5'd7, 1'b0});
            chk("bp_rdy", 64'(rdy1), 64'd0);
            chk("bp_opm", 64'(opm1), 64'd0);
            step();
        end
        rr1 = 1'b1;
        q1.push_back({32'd0, 5'd9, 1'b0});
        step();
        chk("bp_idle_rdy", 64'(rdy1), 64'd1);
        chk("bp_idle_rv", 64'(rv1), 64'd0);
        chk("bp_idle_opm", 64'(opm1), 64'd0);
        step();
        v1 = 1'b0;
        chk("bp_st_opm", 64'(opm1), 64'd1);
        chk("bp_st_pos", {pos1, valor1}, {32'd5, 32'h1234_5678});
        step();
        chk("bp_st_rv", 64'(rv1), 64'd1);
        step();

        // RD_LAT=3
        send(1'b1, 1'b1, 32'd2, 32'hCAFE_F00D, 5'd1, {32'd0, 5'd1, 1'b0});
        step();
        step();
        send(1'b1, 1'b0, 32'd2, 32'd0, 5'd2, {32'hCAFE_F00D, 5'd2, 1'b0});
        for (int i = 1; i <= 3; i++) begin
            chk("l3_opr", 64'(opr3), 64'd1);
            chk("l3_rv_early", 64'(rv3), 64'd0);
            step();
        end
        chk("l3_opr_drop", 64'(opr3), 64'd0);
        chk("l3_rv", 64'(rv3), 64'd1);
        step();

        // Out-of-range load
`ifdef MEM_ACCESS_BOUNDS_CHK_EN
        send(1'b0, 1'b0, 32'd10, 32'd0, 5'd3, {32'd0, 5'd3, 1'b1});
        chk("oob_rv", 64'(rv1), 64'd1);
        chk("oob_noop", {opm1, opr1}, 64'd0);
        chk("oob_err", 64'(err1), 64'd1);
        step();
        chk("oob_noop2", {opm1, opr1}, 64'd0);
`else
        send(1'b0, 1'b0, 32'd10, 32'd0, 5'd3, {32'hA000_000A, 5'd3, 1'b0});
        chk("far_opr", 64'(opr1), 64'd1);
        chk("far_pos", 64'(pos1), 64'd10);
        step();
        chk("far_rv", 64'(rv1), 64'd1);
        chk("far_err", 64'(err1), 64'd0);
`endif
        step();

        // Reset in the middle of READ_WAIT
        send(1'b1, 1'b0, 32'd2, 32'd0, 5'd6, {32'hCAFE_F00D, 5'd6, 1'b0});
        step();
        chk("mid_state", 64'(opr3), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_opr", 64'(opr3), 64'd0);
        chk("mid_rv", 64'(rv3), 64'd0);
        q3.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rdy", 64'(rdy3), 64'd1);
        chk("post_outs", {opm3, opr3, rv3, err3, rd3}, 64'd0);
        chk("post_pos", {pos3, valor3}, 64'd0);
        chk("post_data", 64'(data3), 64'd0);
        step();

        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
